// File: rtl/seq_tx_1001_if.sv
// seq_tx_1001_if: load handshake and serial line bundle for the framed 1001 transmitter
// Signals:
//   load, data_in                          driven by the producer (master)
//   ready, data_out, frame_active, stuff, done  driven by the transmitter (slave)
interface seq_tx_1001_if #(
  parameter int DATA_W = 8
);
  logic              load;
  logic [DATA_W-1:0] data_in;
  logic              ready;
  logic              data_out;
  logic              frame_active;
  logic              stuff;
  logic              done;
  modport master (
    output load, data_in,
    input  ready, data_out, frame_active, stuff, done
  );
  modport slave (
    input  load, data_in,
    output ready, data_out, frame_active, stuff, done
  );
endinterface

// File: rtl/seq_tx_1001.sv
// seq_tx_1001: framed serial transmitter, optional guard 0, sync 1001, payload MSB-first with bit stuffing
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of seq_tx_1001_if: load/data_in in; ready, data_out, frame_active, stuff, done out (all registered)
module seq_tx_1001 #(
  parameter int DATA_W = 8
) (
  input logic          clk,
  input logic          rst_n,
  seq_tx_1001_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GUARD   = 2'd1;
  localparam logic [1:0] SYNC    = 2'd2;
  localparam logic [1:0] PAYLOAD = 2'd3;
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W);
  logic [1:0]        state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [DATA_W-1:0] sreg, sreg_n;
  logic [2:0]        hist, hist_n;
  logic              dout_n, fa_n, stuff_n, done_n, clr;
  // In SYNC, cnt indexes the sync bit currently on the line; in PAYLOAD it counts payload bits already driven.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sreg_n  = sreg;
    dout_n  = 1'b0;
    fa_n    = 1'b0;
    stuff_n = 1'b0;
    done_n  = 1'b0;
    clr     = 1'b0;
    case (state)
      IDLE: if (bus.load) begin
        sreg_n  = bus.data_in;
        cnt_n   = '0;
        fa_n    = 1'b1;
        state_n = (hist == 3'b100) ? GUARD : SYNC;
        dout_n  = (hist != 3'b100);
      end
      GUARD: begin
        state_n = SYNC;
        dout_n  = 1'b1;
        fa_n    = 1'b1;
      end
      SYNC: begin
        fa_n    = 1'b1;
        clr     = (cnt == CW'(3));
        state_n = clr ? PAYLOAD : SYNC;
        cnt_n   = clr ? CW'(1) : cnt + 1'b1;
        dout_n  = clr ? sreg[DATA_W-1] : (cnt == CW'(2));
        sreg_n  = clr ? sreg << 1 : sreg;
      end
      default: if (cnt == LAST) state_n = IDLE;
      else begin
        fa_n    = 1'b1;
        stuff_n = (hist == 3'b100);
        dout_n  = !stuff_n && sreg[DATA_W-1];
        sreg_n  = stuff_n ? sreg : sreg << 1;
        cnt_n   = stuff_n ? cnt : cnt + 1'b1;
        done_n  = !stuff_n && (cnt == LAST - 1'b1);
      end
    endcase
    // the detector restarts after the sync match, so history is forgotten once the final sync 1 is out
    hist_n = {clr ? 2'b00 : hist[1:0], dout_n};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      sreg             <= '0;
      hist             <= '0;
      bus.data_out     <= 1'b0;
      bus.ready        <= 1'b1;
      bus.frame_active <= 1'b0;
      bus.stuff        <= 1'b0;
      bus.done         <= 1'b0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      sreg             <= sreg_n;
      hist             <= hist_n;
      bus.data_out     <= dout_n;
      bus.ready        <= (state_n == IDLE);
      bus.frame_active <= fa_n;
      bus.stuff        <= stuff_n;
      bus.done         <= done_n;
    end
endmodule

// File: tb/tb_seq_tx_1001.sv
// tb_seq_tx_1001: scoreboard bench with a frame-building reference model and a detector/destuffer on the line
module tb_seq_tx_1001;
  localparam int W = 8;
  typedef struct packed {
    bit d;
    bit s;
    bit dn;
    bit se;
  } rec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  seq_tx_1001_if #(.DATA_W(W)) bus();
  seq_tx_1001 #(.DATA_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  rec_t         exp_q[$];
  logic [W-1:0] pay_q[$];
  bit           line[$];
  int errs = 0, checks = 0;
  int n_acc = 0, n_abort = 0, done_cnt = 0, det_cnt = 0, se_cnt = 0;
  bit dwin[$];
  bit cwin[$];
  bit col = 1'b0;
  bit det;
  int nb, k;
  logic [W-1:0] acc;
  rec_t r;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask
  function automatic bit tail100(input bit q[$]);
    int n = q.size();
    return n >= 3 && q[n-3] && !q[n-2] && !q[n-1];
  endfunction
  task automatic push_rec(input bit d, input bit s, input bit dn, input bit se);
    exp_q.push_back(rec_t'{d, s, dn, se});
    line.push_back(d);
  endtask
  // Expected frame from the line rules: guard if the line tail reads 100, sync, then payload
  // with a 0 inserted whenever the bits since sync/last stuff end in 100.
  task automatic accept(input logic [W-1:0] d);
    bit win[$];
    if (tail100(line)) push_rec(1'b0, 1'b0, 1'b0, 1'b0);
    push_rec(1'b1, 1'b0, 1'b0, 1'b0);
    push_rec(1'b0, 1'b0, 1'b0, 1'b0);
    push_rec(1'b0, 1'b0, 1'b0, 1'b0);
    push_rec(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = W - 1; i >= 0; i--) begin
      if (tail100(win)) begin
        push_rec(1'b0, 1'b1, 1'b0, 1'b0);
        win.delete();
      end
      push_rec(d[i], 1'b0, i == 0, 1'b0);
      win.push_back(d[i]);
    end
    pay_q.push_back(d);
    n_acc++;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.ready) line.push_back(1'b0);
  endtask
  task automatic send(input logic [W-1:0] d, input int gap, input bit hold);
    int t = 0;
    bus.data_in = d;
    bus.load = hold;
    while (!bus.ready) begin
      step();
      if (++t > 100) begin
        $display("FAIL ready_timeout: ready still low after %0d cycles", t);
        $fatal(1, "ready timeout");
      end
    end
    repeat (gap) begin
      bus.load = 1'b0;
      step();
    end
    bus.load = 1'b1;
    accept(d);
    step();
    bus.load = 1'b0;
    bus.data_in = W'($urandom);
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      dwin.delete();
      cwin.delete();
      col = 1'b0;
    end else begin
      chk("ready_vs_active", bus.ready, !bus.frame_active);
      dwin.push_back(bus.data_out);
      k = dwin.size();
      det = k >= 4 && dwin[k-4] && !dwin[k-3] && !dwin[k-2] && dwin[k-1];
      if (bus.frame_active) begin
        if (exp_q.size() == 0) chk("unexpected_frame_bit", 1, 0);
        else begin
          r = exp_q.pop_front();
          chk("frame_bit{d,stuff,done,det}", {bus.data_out, bus.stuff, bus.done, det}, {r.d, r.s, r.dn, r.se});
          if (r.se) se_cnt++;
        end
      end else chk("idle_bit{d,stuff,done,det}", {bus.data_out, bus.stuff, bus.done, det}, 0);
      if (col) begin
        if (tail100(cwin)) cwin.delete();
        else begin
          acc = {acc[W-2:0], bus.data_out};
          cwin.push_back(bus.data_out);
          if (++nb == W) begin
            col = 1'b0;
            if (pay_q.size() == 0) chk("unexpected_payload", 1, 0);
            else chk("recovered_payload", acc, pay_q.pop_front());
          end
        end
      end
      if (det) begin
        det_cnt++;
        col = 1'b1;
        nb = 0;
        cwin.delete();
        dwin.delete();
      end
      if (bus.done) done_cnt++;
    end
  end
  initial begin
    bus.load = 1'b0;
    bus.data_in = '0;
    #12;
    chk("reset_outputs{ready,d,fa,stuff,done}", {bus.ready, bus.data_out, bus.frame_active, bus.stuff, bus.done}, 5'b10000);
    #10 rst_n = 1'b1;
    repeat (4) step();
    send(8'h00, 2, 1'b0);
    send(8'hA5, 1, 1'b0);
    send(8'h99, 3, 1'b0);
    send(8'h02, 0, 1'b0);
    send(8'hFF, 0, 1'b1);
    send(8'h5A, 2, 1'b0);
    repeat (6) step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_abort{ready,d,fa,stuff,done}", {bus.ready, bus.data_out, bus.frame_active, bus.stuff, bus.done}, 5'b10000);
    exp_q.delete();
    pay_q.delete();
    n_abort++;
    @(posedge clk);
    #3 rst_n = 1'b1;
    line.delete();
    repeat (3) step();
    for (int i = 0; i < 200; i++) send(W'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    repeat (40) step();
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("payload_queue_drained", pay_q.size(), 0);
    chk("done_count", done_cnt, n_acc - n_abort);
    chk("detections_only_at_sync", det_cnt, se_cnt);
    chk("ready_idle_at_end", bus.ready, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/seq_tx_1001.md
# seq_tx_1001

Framed serial transmitter that produces the bit stream consumed by the team's 1001 Mealy non-overlapping sequence detector. It accepts a parallel payload word, emits the sync pattern 1001, then the payload MSB-first. Bit stuffing and a pre-sync guard bit ensure that 1001 appears on the line only at frame starts. It sits on the transmit side of the serial link, one bit per clock.

## Interface
- DATA_W, 8, payload width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- load  input  1  payload valid; accepted when load && ready at a rising edge
- data_in  input  DATA_W  payload word, sampled on acceptance
- ready  output  1  high only in IDLE; block can accept a word
- data_out  output  1  serial line bit, registered, one bit per cycle
- frame_active  output  1  high while guard, sync or payload bits are on data_out
- stuff  output  1  high in cycles where data_out carries a stuffed 0
- done  output  1  one-cycle pulse, concurrent with the last payload bit

## Operation
- All outputs are registered. Reset values: data_out=0, ready=1, frame_active=0, stuff=0, done=0, state=IDLE. Internal hist=000 and bit counter=0.
- hist holds the last 3 bits driven on data_out, including the current cycle, newest in bit 0. It updates every cycle in every state.
- States:
  - IDLE: data_out=0, ready=1. On acceptance, latch data_in into the shift register. Go to GUARD if hist==100, else go to SYNC.
  - GUARD: drive 0 for 1 cycle, frame_active=1, stuff=0, then go to SYNC.
  - SYNC: drive 1,0,0,1 over 4 cycles. In the cycle after the final 1, treat hist as cleared to 000, because the detector returns to its start state after a detection. Then go to PAYLOAD.
  - PAYLOAD: before driving each payload bit, check hist. If hist==100, drive a stuffed 0 with stuff=1; the payload bit is not consumed and hist becomes 000. Otherwise drive the next payload bit, MSB first. After DATA_W payload bits have been driven, go to IDLE. done=1 with the last payload bit.
- Stuffing is checked before every payload bit, including the first. The first check always fails because hist is 000 after SYNC.
- A stuff may occur immediately before the last payload bit. No stuff is inserted after the last payload bit; the guard bit covers that boundary.
- Frame length is 4 + DATA_W + stuffs (+1 if guarded) cycles.
- ready=0 from the acceptance edge until the cycle after done. load is ignored while ready=0, and data_in is don't-care outside acceptance.
- Async reset mid-frame aborts the frame immediately. All outputs and state go to reset values with no completion pulse.

## Timing
- The first frame bit (guard 0 or sync 1) appears on data_out in the cycle after the acceptance edge.
- The earliest re-acceptance is at the edge ending the first IDLE cycle after done, so back-to-back frames have at least 1 idle 0 between them.
- done, frame_active and stuff are aligned to the data_out bit they describe.
- The guard decision uses hist at the acceptance edge. That hist includes the IDLE 0 driven in that cycle.

## Test plan
- Reset: assert rst_n=0 asynchronously mid-cycle -> data_out=0, ready=1, frame_active=0, stuff=0, done=0 immediately. After release, line stays 0 with no load.
- DATA_W=8, load 0x00 from reset -> stream 1,0,0,1 then 8×0. 12 cycles frame_active, no stuff, done on the 12th bit, ready=1 the next cycle.
- Load 0xA5 -> stream 1001 then 1,0,1,0,0,[0],1,0,1. stuff=1 on the bracketed bit only. Frame is 13 cycles.
- Load 0x99 -> stream 1001 then 1,0,0,[0],1,1,0,0,[0],1. Two stuffs, 14 cycles. A reference 1001 non-overlapping detector model on data_out reports exactly one detection, at the sync.
- Guard: load 0x02, then hold load=1 with 0xFF -> after done, 1 IDLE 0, then GUARD 0, then 1001 and 8 ones. The detector model reports exactly 2 detections over the whole run.
- Random: 200 random payloads with random load gaps -> a detector-plus-destuffer model recovers every payload in order. It sees a detection only at each sync, and ready/done counts match the number of loads.
